bcd_display_driver: RTL and testbench
=====================================

BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

Interface
REQ-001 SHALL have parameter BLANK_CYCLES, default 4: anti-ghosting blank cycles at the start of each digit slot.
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port scan_period, input, 32, clk cycles per digit slot, blank cycles included.
REQ-005 SHALL have ports sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens, input, 4 each, BCD digits from the timekeeping block.
REQ-006 SHALL have port update, input, 1, single-cycle strobe: digit inputs valid, capture them.
REQ-007 SHALL have port lzb_en, input, 1, enables leading-zero blanking of hour_tens.
REQ-008 SHALL have port colon_en, input, 1, lights decimal points on the hour_ones and min_ones digits.
REQ-009 SHALL have port seg, output, 7, {g,f,e,d,c,b,a}, active-high segments.
REQ-010 SHALL have port dp, output, 1, active-high decimal point.
REQ-011 SHALL have port an, output, 6, active-low one-hot digit enables; an[i] selects digit i.
REQ-012 SHALL have port frame_start, output, 1, one-cycle pulse when the digit 0 slot begins.

Function
REQ-013 SHALL use digit index idx 0..5 mapped to sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens.
REQ-014 SHALL keep slot counter cnt, 32-bit; effective period P = max(scan_period, BLANK_CYCLES+1), sampled at the edge where cnt returns to 0.
REQ-015 SHALL increment cnt each cycle; at cnt==P-1: cnt<=0 and idx<=(idx==5)?0:idx+1.
REQ-016 SHALL run a two-state per-slot FSM: BLANK while cnt<BLANK_CYCLES, DRIVE while cnt>=BLANK_CYCLES.
REQ-017 SHALL, in BLANK, drive an=6'b111111, seg=0, dp=0.
REQ-018 SHALL, in DRIVE, drive an=~(6'b1<<idx) with seg/dp for the active digit idx.
REQ-019 SHALL decode seg as 0..9 -> 3F,06,5B,4F,66,6D,7D,07,7F,6F hex; any value 10..15 -> 40 hex (dash).
REQ-020 SHALL force seg=0 for idx 5 when lzb_en=1 and active hour_tens==0; the anode is still enabled.
REQ-021 SHALL drive dp=colon_en in DRIVE for idx 2 and idx 4, and dp=0 otherwise.
REQ-022 SHALL decode seg, dp and an only from registered state plus lzb_en/colon_en; digit inputs never reach the outputs combinationally.
REQ-023 SHALL double-buffer: update=1 loads a pending bank from the digit inputs and sets pending_valid.
REQ-024 SHALL, on the edge entering idx 0 / cnt 0, copy pending to the active bank if pending_valid=1, clear pending_valid, and assert frame_start for that cycle.
REQ-025 SHALL, when update coincides with the frame-start edge, load the digit inputs directly into the active bank and leave pending_valid=0.
REQ-026 SHALL let a newer update overwrite pending; only the last update before a frame start is displayed.
REQ-027 SHALL never change active digits mid-frame; all six digits of one frame come from a single update.

Reset
REQ-028 SHALL, on reset low, immediately clear cnt, idx, both banks, pending_valid and frame_start to 0.
REQ-029 SHALL, during reset, hold an=6'b111111, seg=0, dp=0 independent of clk.
REQ-030 SHALL start in BLANK of the idx-0 slot, first edge after release; no frame_start pulse for this first frame.
REQ-031 SHALL, on reset asserted mid-slot or mid-update, discard pending data; nothing is displayed until the next update plus frame start.

Verification
REQ-032 SHALL cover: BLANK_CYCLES=4, scan_period=10 -> per slot 4 cycles an=3F then 6 cycles DRIVE; idx order 0..5; frame_start every 60 cycles.
REQ-033 SHALL cover: update with digits 12:34:56 -> after next frame_start, slot 0 seg=7D, slot 5 seg=06; dp lit in slots 2 and 4 with colon_en=1.
REQ-034 SHALL cover: update mid-frame (idx 3) -> remaining slots still show old digits; new digits appear from next frame_start.
REQ-035 SHALL cover: update on frame-start edge -> new digits shown in the same frame; two updates in one frame -> only the second is displayed.
REQ-036 SHALL cover: hour_tens=0 with lzb_en=1 -> slot 5 seg=00, an=1F; hour_tens=0 with lzb_en=0 -> seg=3F; digit value 12 -> seg=40.
REQ-037 SHALL cover: scan_period=2 -> effective P=5 (1 DRIVE cycle); reset low mid-DRIVE -> an=3F, seg=00 asynchronously, idx=0 after release.

Source files
------------

// File: rtl/bcd_display_driver_if.sv
// bcd_display_driver_if -- bundle between the timekeeping side and the
// multiplexed 6-digit 7-segment display driver.
//   scan_period           : clk cycles per digit slot (blank cycles included)
//   sec/min/hour_ones/tens: BCD digits, captured on update
//   update                : single-cycle capture strobe
//   lzb_en / colon_en     : leading-zero blanking / colon decimal points
//   seg / dp / an         : segment {g..a}, decimal point, active-low anodes
//   frame_start           : one-cycle pulse as the digit 0 slot begins
// master = digit source / display consumer, slave = the driver.
interface bcd_display_driver_if;
  logic [31:0] scan_period;
  logic [3:0]  sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens;
  logic        update;
  logic        lzb_en;
  logic        colon_en;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  an;
  logic        frame_start;

  modport master (
    output scan_period, sec_ones, sec_tens, min_ones, min_tens, hour_ones,
           hour_tens, update, lzb_en, colon_en,
    input  seg, dp, an, frame_start
  );

  modport slave (
    input  scan_period, sec_ones, sec_tens, min_ones, min_tens, hour_ones,
           hour_tens, update, lzb_en, colon_en,
    output seg, dp, an, frame_start
  );
endinterface

// File: rtl/bcd_display_driver.sv
// bcd_display_driver -- time-multiplexed driver for a 6-digit 7-segment
// display (HH:MM:SS). Each digit slot lasts P = max(scan_period,
// BLANK_CYCLES+1) cycles: BLANK_CYCLES with all anodes off (anti-ghosting),
// then the rest driving one digit. Digits are double-buffered so a frame
// always shows a single consistent update.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : bcd_display_driver_if.slave (digits, strobes, display outputs)
module bcd_display_driver #(
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_display_driver_if.slave  bus
);

  localparam logic [31:0] BLK   = 32'(BLANK_CYCLES);
  localparam logic [31:0] MIN_P = 32'(BLANK_CYCLES) + 32'd1;

  typedef enum logic {ST_BLANK, ST_DRIVE} state_e;
  localparam state_e ST_RST = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

  state_e            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       per_q;
  logic              run_q;
  logic [2:0]        idx_q, idx_d;
  logic [5:0][3:0]   act_q, act_d, pend_q, pend_d;
  logic              pv_q, pv_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [5:0]        an_q, an_d;
  logic              fs_q;

  logic [5:0][3:0]   din;
  logic [31:0]       eff_p, cur_p;
  logic              last, frame_edge;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h40;  // non-BCD shows a dash
    endcase
  endfunction

  always_comb begin
    din = {bus.hour_tens, bus.hour_ones, bus.min_tens, bus.min_ones,
           bus.sec_tens, bus.sec_ones};
    eff_p = (bus.scan_period < MIN_P) ? MIN_P : bus.scan_period;
    // Period is latched as each slot begins; the very first slot after reset
    // has no latched value yet, so it follows the live input.
    cur_p = run_q ? per_q : eff_p;
    last       = (cnt_q == cur_p - 32'd1);
    frame_edge = last && (idx_q == 3'd5);

    cnt_d = last ? 32'd0 : cnt_q + 32'd1;
    idx_d = idx_q;
    if (last) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

    // Active bank only changes on the frame boundary; an update landing on
    // that very edge goes straight to the active bank.
    act_d  = act_q;
    pend_d = pend_q;
    pv_d   = pv_q;
    if (frame_edge) begin
      pv_d = 1'b0;
      if (bus.update)  act_d = din;
      else if (pv_q)   act_d = pend_q;
    end else if (bus.update) begin
      pend_d = din;
      pv_d   = 1'b1;
    end

    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_d >= BLK) state_d = ST_DRIVE;
      ST_DRIVE: if (cnt_d <  BLK) state_d = ST_BLANK;
      default:  state_d = ST_RST;
    endcase

    // Outputs are registered from next state so they line up with cnt_q.
    an_d  = 6'h3F;
    seg_d = 7'h00;
    dp_d  = 1'b0;
    if (state_d == ST_DRIVE) begin
      an_d  = ~(6'b1 << idx_d);
      seg_d = seg7(act_d[idx_d]);
      if (idx_d == 3'd5 && bus.lzb_en && act_d[5] == 4'd0) seg_d = 7'h00;
      dp_d  = bus.colon_en && (idx_d == 3'd2 || idx_d == 3'd4);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RST;
      cnt_q   <= 32'd0;
      per_q   <= MIN_P;
      run_q   <= 1'b0;
      idx_q   <= 3'd0;
      act_q   <= '0;
      pend_q  <= '0;
      pv_q    <= 1'b0;
      an_q    <= 6'h3F;
      seg_q   <= 7'h00;
      dp_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
      if (!run_q || last) per_q <= eff_p;
      idx_q   <= idx_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fs_q    <= frame_edge;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
module tb_bcd_display_driver;
  localparam int BLANK = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bcd_display_driver_if bus();
  bcd_display_driver #(.BLANK_CYCLES(BLANK)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [5:0][3:0] dig;   // idx5..idx0
    bit              lzb;
    bit              colon;
    logic [5:0][6:0] seg;   // expected seg per slot, idx5..idx0
  } vec_t;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } obs_t;

  vec_t tbl[5];
  vec_t rz;
  obs_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    bus.sec_ones  = r.dig[0];
    bus.sec_tens  = r.dig[1];
    bus.min_ones  = r.dig[2];
    bus.min_tens  = r.dig[3];
    bus.hour_ones = r.dig[4];
    bus.hour_tens = r.dig[5];
  endtask

  task automatic pulse(input vec_t r);
    drive(r);
    bus.update = 1'b1;
    @(negedge clk);
    bus.update = 1'b0;
  endtask

  task automatic setmode(input vec_t r);
    bus.lzb_en   = r.lzb;
    bus.colon_en = r.colon;
  endtask

  task automatic wait_fs(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.frame_start && cnt < 300);
    if (!bus.frame_start) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_start timeout: got none after %0d cycles", cnt);
    end
  endtask

  // Called at the negedge where frame_start is high; checks one whole frame
  // of p-cycle slots and returns at the start of the next frame.
  task automatic check_frame(input vec_t r, input int p);
    int k;
    for (int c = 0; c < 6 * p; c++) begin
      int   s, ph;
      obs_t e;
      s = c / p;
      ph = c % p;
      e.fs = (c == 0);
      if (ph < BLANK) begin
        e.an = 6'h3F; e.seg = 7'h00; e.dp = 1'b0;
      end else begin
        e.an  = 6'h3F ^ (6'b1 << s);
        e.seg = r.seg[s];
        e.dp  = r.colon && (s == 2 || s == 4);
      end
      sb.push_back(e);
    end
    k = 0;
    while (sb.size() > 0) begin
      obs_t e, a;
      e = sb.pop_front();
      a = {bus.an, bus.seg, bus.dp, bus.frame_start};
      chk($sformatf("frame cycle %0d {an,seg,dp,fs}", k), 32'(a), 32'(e));
      k++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{dig:{4'd1,4'd2,4'd3,4'd4,4'd5,4'd6}, lzb:1'b0, colon:1'b1,
               seg:{7'h06,7'h5B,7'h4F,7'h66,7'h6D,7'h7D}};
    tbl[1] = '{dig:{4'd0,4'd9,4'd5,4'd9,4'd0,4'd7}, lzb:1'b1, colon:1'b0,
               seg:{7'h00,7'h6F,7'h6D,7'h6F,7'h3F,7'h07}};
    tbl[2] = '{dig:{4'd0,4'd9,4'd5,4'd9,4'd0,4'd7}, lzb:1'b0, colon:1'b0,
               seg:{7'h3F,7'h6F,7'h6D,7'h6F,7'h3F,7'h07}};
    tbl[3] = '{dig:{4'd15,4'd13,4'd12,4'd11,4'd10,4'd8}, lzb:1'b1, colon:1'b1,
               seg:{7'h40,7'h40,7'h40,7'h40,7'h40,7'h7F}};
    tbl[4] = '{dig:{4'd0,4'd4,4'd3,4'd2,4'd1,4'd0}, lzb:1'b0, colon:1'b0,
               seg:{7'h3F,7'h66,7'h4F,7'h5B,7'h06,7'h3F}};
    rz     = '{dig:'0, lzb:1'b0, colon:1'b0,
               seg:{7'h3F,7'h3F,7'h3F,7'h3F,7'h3F,7'h3F}};

    bus.scan_period = 32'd10;
    bus.update = 1'b0;
    drive(rz);
    setmode(rz);

    // reset state
    #23;
    chk("reset an", 32'(bus.an), 32'h3F);
    chk("reset seg", 32'(bus.seg), 32'h00);
    chk("reset dp", 32'(bus.dp), 32'h0);
    chk("reset frame_start", 32'(bus.frame_start), 32'h0);

    @(negedge clk);
    reset = 1'b1;
    wait_fs(n);
    chk("first frame_start edge count", n, 60);

    // table: each update displayed from the following frame
    for (int i = 0; i < 5; i++) begin
      pulse(tbl[i]);
      wait_fs(n);
      chk($sformatf("vec %0d frame_start spacing", i), n, 59);
      setmode(tbl[i]);
      check_frame(tbl[i], 10);
    end

    // update mid-frame (slot 3): current frame keeps old digits
    fork
      check_frame(tbl[4], 10);
      begin repeat (35) @(negedge clk); pulse(tbl[0]); end
    join
    setmode(tbl[0]);
    check_frame(tbl[0], 10);

    // update on the frame-start edge: shown in that same frame
    fork
      check_frame(tbl[0], 10);
      begin repeat (59) @(negedge clk); pulse(tbl[1]); end
    join
    setmode(tbl[1]);
    check_frame(tbl[1], 10);

    // two updates in one frame: only the second shows
    fork
      check_frame(tbl[1], 10);
      begin
        repeat (10) @(negedge clk); pulse(tbl[2]);
        repeat (19) @(negedge clk); pulse(tbl[3]);
      end
    join
    setmode(tbl[3]);

    // scan_period=2 mid slot 5: takes effect at the next slot, P=5
    fork
      check_frame(tbl[3], 10);
      begin repeat (55) @(negedge clk); bus.scan_period = 32'd2; end
    join
    check_frame(tbl[3], 5);

    // reset mid-DRIVE with an update pending
    pulse(tbl[0]);
    repeat (3) @(negedge clk);
    chk("pre-reset drive an", 32'(bus.an), 32'h3E);
    #2 reset = 1'b0;
    #1;
    chk("async reset an", 32'(bus.an), 32'h3F);
    chk("async reset seg", 32'(bus.seg), 32'h00);
    chk("async reset dp", 32'(bus.dp), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("post-reset slot0 an", 32'(bus.an), 32'h3E);
    chk("post-reset slot0 seg", 32'(bus.seg), 32'h3F);
    wait_fs(n);
    chk("post-reset frame_start count", n, 26);
    setmode(rz);
    check_frame(rz, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
